// File: rtl/sda_kernel_axi_pkg.sv
// Shared AXI definitions for the SDA kernel: burst/size/resp encodings,
// ARLEN width, requester limit, arbiter state encoding and a clog2 helper.
package sda_kernel_axi_pkg;

    localparam int unsigned AXI_LEN_WIDTH = 8;
    localparam int unsigned AXI_MAX_REQ   = 8;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi_burst_e;

    typedef enum logic [2:0] {
        AXI_SIZE_1B   = 3'd0,
        AXI_SIZE_2B   = 3'd1,
        AXI_SIZE_4B   = 3'd2,
        AXI_SIZE_8B   = 3'd3,
        AXI_SIZE_16B  = 3'd4,
        AXI_SIZE_32B  = 3'd5,
        AXI_SIZE_64B  = 3'd6,
        AXI_SIZE_128B = 3'd7
    } axi_size_e;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_ISSUE = 1'b1
    } arb_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/sda_kernel_rd_order_fifo.sv
// Register FIFO recording the requester index of each issued read burst,
// in grant order; the head names the owner of the R burst in flight.
module sda_kernel_rd_order_fifo
    import sda_kernel_axi_pkg::*;
#(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PTR_WIDTH = clog2(DEPTH);
    localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0] count;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_WIDTH'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so push is legal at full
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Storage, pointers (wrap modulo DEPTH) and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sda_kernel_gmem_rd_arbiter.sv
// Shares the kernel's single gmem AXI read master between NUM_REQ requesters.
// AR requests are granted round-robin (one AR per two cycles), the grant order
// is kept in an order FIFO and in-order R bursts are routed to their owner.
// Build option: GMEM_RD_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins).
module sda_kernel_gmem_rd_arbiter
    import sda_kernel_axi_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned IDX_WIDTH       = clog2(NUM_REQ)
) (
    input  logic                               ap_clk,
    input  logic                               ap_rst_n,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_araddr,
    input  logic [NUM_REQ*AXI_LEN_WIDTH-1:0]   req_arlen,
    input  logic [NUM_REQ-1:0]                 req_arvalid,
    output logic [NUM_REQ-1:0]                 req_arready,
    output logic [DATA_WIDTH-1:0]              req_rdata,
    output logic [1:0]                         req_rresp,
    output logic                               req_rlast,
    output logic [NUM_REQ-1:0]                 req_rvalid,
    input  logic [NUM_REQ-1:0]                 req_rready,
    output logic [ADDR_WIDTH-1:0]              m_axi_gmem_ARADDR,
    output logic [AXI_LEN_WIDTH-1:0]           m_axi_gmem_ARLEN,
    output logic                               m_axi_gmem_ARVALID,
    input  logic                               m_axi_gmem_ARREADY,
    input  logic [DATA_WIDTH-1:0]              m_axi_gmem_RDATA,
    input  logic [1:0]                         m_axi_gmem_RRESP,
    input  logic                               m_axi_gmem_RLAST,
    input  logic                               m_axi_gmem_RVALID,
    output logic                               m_axi_gmem_RREADY,
    output logic                               busy
);

    arb_state_e              state_q;
    arb_state_e              state_d;
    logic [IDX_WIDTH-1:0]    rr_ptr;
    logic [IDX_WIDTH-1:0]    cand;
    logic [IDX_WIDTH-1:0]    grant_idx;
    logic                    grant_valid;
    logic                    grant_en;
    logic [ADDR_WIDTH-1:0]   ar_addr_q;
    logic [AXI_LEN_WIDTH-1:0] ar_len_q;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_pop;
    logic [IDX_WIDTH-1:0]    fifo_head;

    // Pick the first valid requester at or after rr_ptr, wrapping around
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IDX_WIDTH'((k + 32'(rr_ptr)) % NUM_REQ);
            if (!grant_valid && req_arvalid[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Arbiter next state: grant in IDLE when the order FIFO has room, hold AR in ISSUE
    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (grant_valid && !fifo_full) begin
                    grant_en = 1'b1;
                    state_d  = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (m_axi_gmem_ARREADY) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Arbiter state register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // AR payload captured from the granted requester, held stable through ISSUE
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ar_addr_q <= '0;
            ar_len_q  <= '0;
        end else if (grant_en) begin
            ar_addr_q <= req_araddr[32'(grant_idx) * ADDR_WIDTH +: ADDR_WIDTH];
            ar_len_q  <= req_arlen[32'(grant_idx) * AXI_LEN_WIDTH +: AXI_LEN_WIDTH];
        end
    end

    // Round-robin pointer moves just past each winner; pinned to 0 for fixed priority
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rr_ptr <= '0;
        end else begin
`ifdef GMEM_RD_ARB_FIXED_PRIO_EN
            rr_ptr <= '0;
`else
            if (grant_en) begin
                rr_ptr <= (grant_idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
`endif
        end
    end

    assign req_arready        = grant_en ? (NUM_REQ'(1) << grant_idx) : '0;
    assign m_axi_gmem_ARVALID = (state_q == ARB_ISSUE);
    assign m_axi_gmem_ARADDR  = ar_addr_q;
    assign m_axi_gmem_ARLEN   = ar_len_q;

    // R path is purely combinational; an empty FIFO blocks stray beats
    assign m_axi_gmem_RREADY = req_rready[fifo_head] & ~fifo_empty;
    assign req_rvalid        = fifo_empty ? '0 : (NUM_REQ'(m_axi_gmem_RVALID) << fifo_head);
    assign req_rdata         = m_axi_gmem_RDATA;
    assign req_rresp         = m_axi_gmem_RRESP;
    assign req_rlast         = m_axi_gmem_RLAST;
    assign fifo_pop          = m_axi_gmem_RVALID & m_axi_gmem_RREADY & m_axi_gmem_RLAST;

    assign busy = (state_q == ARB_ISSUE) | ~fifo_empty;

    sda_kernel_rd_order_fifo #(
        .WIDTH (IDX_WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_order_fifo (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .push      (grant_en),
        .push_data (grant_idx),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

endmodule
